as6d_app_video_status_buffer_ctrl: RTL and testbench

Single-clock FIFO controller that sits directly in front of and behind `as6d_app_video_status_buffer_1r1w_16x102_ram_wrapper`. It turns a valid/ready push stream into RAM write strobes. It prefetches RAM reads and absorbs the 2-cycle read latency in a skid buffer, presenting a valid/ready pop stream. It also aligns the wrapper's ECC flags with each popped word and accumulates error statistics for the video status path.

---
 rtl/as6d_app_vsb_pkg.sv | 17 +
 rtl/as6d_app_vsb_skid.sv | 44 ++++
 rtl/as6d_app_video_status_buffer_ctrl.sv | 140 ++++++++++++++
 tb/tb_as6d_app_video_status_buffer_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/as6d_app_vsb_pkg.sv
// rtl/as6d_app_vsb_pkg.sv - shared parameters and skid entry type for the video status buffer controller
package as6d_app_vsb_pkg;

    localparam int VSB_ADDR_WIDTH    = 4;
    localparam int VSB_DATA_WIDTH    = 102;
    localparam int VSB_RD_LATENCY    = 2;
    localparam int VSB_ERR_CNT_WIDTH = 8;
    localparam int VSB_SKID_DEPTH    = 2;

    typedef struct packed {
        logic [VSB_DATA_WIDTH-1:0] data;
        logic                      sbit;
        logic                      dbit;
        logic                      fault;
    } skid_entry_t;

endpackage

// File: rtl/as6d_app_vsb_skid.sv
// rtl/as6d_app_vsb_skid.sv - 2-entry in-order skid FIFO; upstream never pushes without a free credit
module as6d_app_vsb_skid
    import as6d_app_vsb_pkg::*;
#(
    parameter type entry_t = skid_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tvalid,
    input  entry_t     s_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output entry_t     m_tdata,
    output logic [1:0] occ
);

    entry_t     mem [2];
    logic       wr_idx;
    logic       rd_idx;
    logic [1:0] count;
    logic       pop;

    assign pop      = m_tvalid && m_tready;
    assign m_tvalid = (count != 2'd0);
    assign m_tdata  = mem[rd_idx];
    assign occ      = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (s_tvalid) wr_idx <= ~wr_idx;
            if (pop)      rd_idx <= ~rd_idx;
            count <= count + 2'(s_tvalid) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (s_tvalid) mem[wr_idx] <= s_tdata;
    end

endmodule

// File: rtl/as6d_app_video_status_buffer_ctrl.sv
// rtl/as6d_app_video_status_buffer_ctrl.sv - FIFO controller around the 16x102 ECC RAM wrapper with prefetch and error stats
module as6d_app_video_status_buffer_ctrl
    import as6d_app_vsb_pkg::*;
#(
    parameter int ADDR_WIDTH    = VSB_ADDR_WIDTH,
    parameter int DATA_WIDTH    = VSB_DATA_WIDTH,
    parameter int RD_LATENCY    = VSB_RD_LATENCY,
    parameter int ERR_CNT_WIDTH = VSB_ERR_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_sbit_err,
    output logic                     rd_dbit_err,
    output logic                     rd_ecc_fault,
    output logic [ADDR_WIDTH-1:0]    AA_F,
    output logic [ADDR_WIDTH-1:0]    AB_F,
    output logic                     CSA_F,
    output logic                     WEA_F,
    output logic                     CSB_F,
    output logic                     REB_F,
    output logic [DATA_WIDTH-1:0]    DA_F,
    input  logic [DATA_WIDTH-1:0]    QB_F,
    input  logic                     SINGLE_ERR_B,
    input  logic                     DOUBLE_ERR_B,
    input  logic                     ECC_FAULT_B,
    output logic [ADDR_WIDTH+1:0]    level,
    output logic                     full,
    output logic                     empty,
    output logic [ERR_CNT_WIDTH-1:0] sbit_cnt,
    output logic [ERR_CNT_WIDTH-1:0] dbit_cnt,
    output logic                     dbit_sticky,
    output logic                     fault_sticky,
    input  logic                     err_clr
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int LVL_W = ADDR_WIDTH + 2;
    localparam logic [PTR_W-1:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      ra_ptr;
    logic [PTR_W-1:0]      ram_occ;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [1:0]            inflight;
    logic [1:0]            skid_occ;
    logic [2:0]            credits_used;
    logic                  push;
    logic                  issue;
    logic                  pop;
    logic                  ev_sbit;
    logic                  ev_dbit;
    logic                  ev_fault;
    skid_entry_t           skid_in;
    skid_entry_t           skid_head;

    // ram_occ is built from registered pointers, so it never counts a same-cycle push
    assign ram_occ      = wr_ptr - ra_ptr;
    assign full         = (ram_occ == RAM_DEPTH);
    assign wr_rdy       = !rst && !full;
    assign push         = wr_vld && wr_rdy;
    assign inflight     = 2'($countones(rd_pipe));
    assign credits_used = {1'b0, inflight} + {1'b0, skid_occ};
    assign issue        = !rst && (ram_occ != '0) && (credits_used < 3'(VSB_SKID_DEPTH));

    assign CSA_F = push;
    assign WEA_F = push;
    assign AA_F  = wr_ptr[ADDR_WIDTH-1:0];
    assign DA_F  = wr_data;
    assign CSB_F = issue;
    assign REB_F = issue;
    assign AB_F  = ra_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            ra_ptr  <= '0;
            rd_pipe <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(push);
            ra_ptr  <= ra_ptr + PTR_W'(issue);
            rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(issue);
        end
    end

    assign skid_in = '{data: QB_F, sbit: SINGLE_ERR_B, dbit: DOUBLE_ERR_B, fault: ECC_FAULT_B};

    as6d_app_vsb_skid #(
        .entry_t (skid_entry_t)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (rd_pipe[RD_LATENCY-1]),
        .s_tdata  (skid_in),
        .m_tvalid (rd_vld),
        .m_tready (rd_rdy),
        .m_tdata  (skid_head),
        .occ      (skid_occ)
    );

    assign rd_data      = skid_head.data;
    assign rd_sbit_err  = skid_head.sbit;
    assign rd_dbit_err  = skid_head.dbit;
    assign rd_ecc_fault = skid_head.fault;

    assign level = LVL_W'(ram_occ) + LVL_W'(inflight) + LVL_W'(skid_occ);
    assign empty = (level == '0);

    assign pop      = rd_vld && rd_rdy;
    assign ev_sbit  = pop && rd_sbit_err;
    assign ev_dbit  = pop && rd_dbit_err;
    assign ev_fault = pop && rd_ecc_fault;

    // A clear in the same cycle as a flagged pop keeps that pop's event
    always_ff @(posedge clk) begin
        if (rst) begin
            sbit_cnt     <= '0;
            dbit_cnt     <= '0;
            dbit_sticky  <= 1'b0;
            fault_sticky <= 1'b0;
        end else begin
            if (err_clr)
                sbit_cnt <= ERR_CNT_WIDTH'(ev_sbit);
            else if (ev_sbit && (sbit_cnt != '1))
                sbit_cnt <= sbit_cnt + ERR_CNT_WIDTH'(1);
            if (err_clr)
                dbit_cnt <= ERR_CNT_WIDTH'(ev_dbit);
            else if (ev_dbit && (dbit_cnt != '1))
                dbit_cnt <= dbit_cnt + ERR_CNT_WIDTH'(1);
            dbit_sticky  <= (dbit_sticky && !err_clr) || ev_dbit;
            fault_sticky <= (fault_sticky && !err_clr) || ev_fault;
        end
    end

endmodule

// File: tb/tb_as6d_app_video_status_buffer_ctrl.sv
// tb/tb_as6d_app_video_status_buffer_ctrl.sv - self-checking bench with RAM model, queue scoreboard and stats model
module tb_as6d_app_video_status_buffer_ctrl;

    localparam int DW = 102;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_vld, wr_rdy, rd_vld, rd_rdy, err_clr;
    logic [DW-1:0] wr_data, rd_data, DA_F, QB_F;
    logic          rd_sbit_err, rd_dbit_err, rd_ecc_fault;
    logic [AW-1:0] AA_F, AB_F;
    logic          CSA_F, WEA_F, CSB_F, REB_F;
    logic          SINGLE_ERR_B, DOUBLE_ERR_B, ECC_FAULT_B;
    logic [AW+1:0] level;
    logic          full, empty, dbit_sticky, fault_sticky;
    logic [7:0]    sbit_cnt, dbit_cnt;
    logic          inj_s, inj_d, inj_f;

    always #5 clk = ~clk;

    as6d_app_video_status_buffer_ctrl dut (
        .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_data(rd_data),
        .rd_sbit_err(rd_sbit_err), .rd_dbit_err(rd_dbit_err), .rd_ecc_fault(rd_ecc_fault),
        .AA_F(AA_F), .AB_F(AB_F), .CSA_F(CSA_F), .WEA_F(WEA_F), .CSB_F(CSB_F), .REB_F(REB_F),
        .DA_F(DA_F), .QB_F(QB_F), .SINGLE_ERR_B(SINGLE_ERR_B), .DOUBLE_ERR_B(DOUBLE_ERR_B),
        .ECC_FAULT_B(ECC_FAULT_B), .level(level), .full(full), .empty(empty),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .dbit_sticky(dbit_sticky),
        .fault_sticky(fault_sticky), .err_clr(err_clr)
    );

    // RAM wrapper model: 2-cycle read latency, flags stored per word at write time
    logic [DW-1:0] mem [16];
    logic [2:0]    fmem [16];
    logic [DW-1:0] rd_s1;
    logic [2:0]    f_s1;
    always @(posedge clk) begin
        if (CSA_F && WEA_F) begin
            mem[AA_F]  <= DA_F;
            fmem[AA_F] <= {inj_s, inj_d, inj_f};
        end
        if (CSB_F && REB_F) begin
            rd_s1 <= mem[AB_F];
            f_s1  <= fmem[AB_F];
        end
        QB_F <= rd_s1;
        {SINGLE_ERR_B, DOUBLE_ERR_B, ECC_FAULT_B} <= f_s1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        bit s, d, f;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            m_s, m_d;
    bit            m_ds, m_fs, hold_v, pop_now, ev_s, ev_d, ev_f;
    logic [DW-1:0] hold_d;

    // Scoreboard: level is simply the number of accepted-but-unpopped words
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_s = 0; m_d = 0; m_ds = 0; m_fs = 0; hold_v = 0;
        end else begin
            chk("level", level, q.size());
            chk("empty", empty, q.size() == 0);
            chk("sbit_cnt", sbit_cnt, m_s);
            chk("dbit_cnt", dbit_cnt, m_d);
            chk("dbit_sticky", dbit_sticky, m_ds);
            chk("fault_sticky", fault_sticky, m_fs);
            if (hold_v) begin
                chk("hold_vld", rd_vld, 1);
                chk("hold_data", rd_data, hold_d);
            end
            hold_v  = rd_vld && !rd_rdy;
            hold_d  = rd_data;
            pop_now = rd_vld && rd_rdy;
            ev_s = 0; ev_d = 0; ev_f = 0;
            if (pop_now) begin
                if (q.size() == 0) chk("pop_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rd_data", rd_data, e.data);
                    chk("rd_sbit_err", rd_sbit_err, e.s);
                    chk("rd_dbit_err", rd_dbit_err, e.d);
                    chk("rd_ecc_fault", rd_ecc_fault, e.f);
                    ev_s = e.s; ev_d = e.d; ev_f = e.f;
                end
            end
            if (err_clr) begin
                m_s = ev_s ? 1 : 0;
                m_d = ev_d ? 1 : 0;
            end else begin
                if (ev_s && m_s < 255) m_s++;
                if (ev_d && m_d < 255) m_d++;
            end
            m_ds = (m_ds && !err_clr) || ev_d;
            m_fs = (m_fs && !err_clr) || ev_f;
            if (wr_vld && wr_rdy) q.push_back('{wr_data, inj_s, inj_d, inj_f});
        end
    end

    function automatic logic [DW-1:0] rnd_word();
        logic [127:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom()};
        return w[DW-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input bit s, input bit dd, input bit f);
        int n;
        wr_vld = 1; wr_data = d; inj_s = s; inj_d = dd; inj_f = f;
        n = 0;
        @(negedge clk);
        while (!wr_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!wr_rdy) chk("push_timeout", 0, 1);
        step();
        wr_vld = 0; inj_s = 0; inj_d = 0; inj_f = 0;
    endtask

    task automatic wait_rd_vld();
        int n;
        n = 0;
        @(negedge clk);
        while (!rd_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rd_vld) chk("rd_vld_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        rd_rdy = 1;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        step();
        rd_rdy = 0;
    endtask

    typedef struct {
        bit s, d, f, clr;
        int es, ed;
        bit eds, efs;
    } row_t;
    row_t rows[8];

    logic [DW-1:0] w;

    initial begin
        rows[0] = '{1, 0, 0, 0, 1, 0, 0, 0};
        rows[1] = '{0, 1, 0, 0, 1, 1, 1, 0};
        rows[2] = '{0, 0, 1, 0, 1, 1, 1, 1};
        rows[3] = '{1, 1, 0, 0, 2, 2, 1, 1};
        rows[4] = '{0, 0, 0, 1, 0, 0, 0, 0};
        rows[5] = '{1, 0, 0, 0, 1, 0, 0, 0};
        rows[6] = '{0, 1, 0, 1, 0, 1, 1, 0};
        rows[7] = '{1, 0, 1, 1, 1, 0, 0, 1};

        rst = 1; wr_vld = 0; wr_data = '0; rd_rdy = 0; err_clr = 0;
        inj_s = 0; inj_d = 0; inj_f = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_rdy", wr_rdy, 0);
        chk("rst_csa", CSA_F, 0);
        chk("rst_csb", CSB_F, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("init_rd_vld", rd_vld, 0);
        chk("init_full", full, 0);
        chk("init_level", level, 0);
        chk("init_wr_rdy", wr_rdy, 1);

        // single push: CSB_F one cycle later, rd_vld four cycles later
        step();
        w = rnd_word();
        wr_vld = 1; wr_data = w;
        @(negedge clk);
        chk("lat_csa", CSA_F, 1);
        chk("lat_wea", WEA_F, 1);
        chk("lat_aa", AA_F, 0);
        chk("lat_da", DA_F, w);
        step();
        wr_vld = 0;
        @(negedge clk);
        chk("lat_csb", CSB_F, 1);
        chk("lat_reb", REB_F, 1);
        chk("lat_ab", AB_F, 0);
        for (int c = 2; c <= 4; c++) begin
            step();
            @(negedge clk);
            chk($sformatf("lat_rd_vld_c%0d", c), rd_vld, c == 4);
        end
        chk("lat_rd_data", rd_data, w);
        step();
        rd_rdy = 1;
        step();
        rd_rdy = 0;

        // fill to full with no pops: 16 in RAM plus 2 prefetched
        for (int i = 0; i < 18; i++) push_word(DW'(i), 0, 0, 0);
        @(negedge clk);
        chk("full_flag", full, 1);
        chk("full_wr_rdy", wr_rdy, 0);
        chk("full_level", level, 18);
        step();
        wr_vld = 1; wr_data = DW'(99);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_stall", wr_rdy, 0);
            step();
        end
        wr_vld = 0;
        rd_rdy = 1;
        step();
        rd_rdy = 0;
        @(negedge clk);
        chk("full_after_pop_rdy", wr_rdy, 0);
        step();
        @(negedge clk);
        chk("full_rdy_rises", wr_rdy, 1);
        chk("full_cleared", full, 0);
        step();
        drain();

        // continuous stream
        rd_rdy = 1;
        for (int i = 0; i < 100; i++) push_word(DW'(1000 + i), 0, 0, 0);
        drain();

        // error statistics table
        for (int r = 0; r < 8; r++) begin
            push_word(rnd_word(), rows[r].s, rows[r].d, rows[r].f);
            wait_rd_vld();
            step();
            rd_rdy = 1; err_clr = rows[r].clr;
            step();
            rd_rdy = 0; err_clr = 0;
            @(negedge clk);
            chk($sformatf("tbl%0d_sbit_cnt", r), sbit_cnt, rows[r].es);
            chk($sformatf("tbl%0d_dbit_cnt", r), dbit_cnt, rows[r].ed);
            chk($sformatf("tbl%0d_dbit_sticky", r), dbit_sticky, rows[r].eds);
            chk($sformatf("tbl%0d_fault_sticky", r), fault_sticky, rows[r].efs);
            step();
        end

        // saturation
        rd_rdy = 1;
        for (int i = 0; i < 300; i++) push_word(rnd_word(), 1, 0, 0);
        drain();
        @(negedge clk);
        chk("sat_sbit_cnt", sbit_cnt, 255);
        step();

        // reset with one word in skid, one read in flight, one in RAM
        wr_vld = 1; wr_data = DW'(501);
        step();
        wr_data = DW'(502);
        step();
        wr_data = DW'(503);
        step();
        wr_vld = 0;
        step();
        @(negedge clk);
        chk("prerst_rd_vld", rd_vld, 1);
        chk("prerst_level", level, 3);
        step();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postrst_rd_vld", rd_vld, 0);
            chk("postrst_level", level, 0);
            step();
        end

        // randomized traffic with random back-pressure, flags and clears
        for (int i = 0; i < 400; i++) begin
            wr_vld  = ($urandom % 3) != 0;
            wr_data = rnd_word();
            inj_s   = ($urandom % 8) == 0;
            inj_d   = ($urandom % 16) == 0;
            inj_f   = ($urandom % 32) == 0;
            rd_rdy  = ($urandom % 2) != 0;
            err_clr = ($urandom % 40) == 0;
            step();
        end
        wr_vld = 0; err_clr = 0; inj_s = 0; inj_d = 0; inj_f = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
